// File: rtl/fx_ctrl_pkg.sv
// rtl/fx_ctrl_pkg.sv - shared types and Q2.22 constants for the float-to-fixed custom instruction
package fx_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONV_A  = 2'd1,
        CONV_B  = 2'd2,
        COMBINE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CONV    = 2'd0,
        SUM2    = 2'd1,
        ACC     = 2'd2,
        READCLR = 2'd3
    } op_t;

    localparam int              FX_W   = 24;
    localparam logic [FX_W-1:0] FX_ONE = 24'h400000;
    localparam logic [FX_W-1:0] FX_MAX = 24'h7FFFFF;
    localparam logic [FX_W-1:0] FX_MIN = 24'h800000;

    // Clamp value for an out-of-range operand, chosen by the float sign
    function automatic logic [FX_W-1:0] fx_clamp(input logic sign);
        return sign ? FX_MIN : FX_MAX;
    endfunction

endpackage

// File: rtl/fx_conv_core.sv
// rtl/fx_conv_core.sv - combinational IEEE-754 single to Q2.22 converter, no saturation
module fx_conv_core
    import fx_ctrl_pkg::*;
(
    input  logic [31:0]     fp,
    output logic [FX_W-1:0] fx
);

    logic            sign;
    logic [7:0]      exp_f;
    logic [22:0]     man;
    logic [7:0]      shamt;
    logic [FX_W-1:0] mag;

    // Shift the hidden-one mantissa into Q2.22; exponents >= 128 yield junk and are clamped upstream
    always_comb begin
        sign  = fp[31];
        exp_f = fp[30:23];
        man   = fp[22:0];
        shamt = 8'd128 - exp_f;
        mag   = {1'b1, man} >> shamt;
        if (exp_f <= 8'd103) begin
            fx = '0;
        end else if (sign) begin
            fx = -mag;
        end else begin
            fx = mag;
        end
    end

endmodule

// File: rtl/fx_conv_ci_ctrl.sv
// rtl/fx_conv_ci_ctrl.sv - multi-cycle custom instruction sharing one converter, with accumulator
module fx_conv_ci_ctrl
    import fx_ctrl_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             start,
    input  logic [1:0]       n,
    input  logic [31:0]      dataa,
    input  logic [31:0]      datab,
    output logic [ACC_W-1:0] result,
    output logic             done
);

    state_t          state;
    state_t          state_nxt;
    op_t             op_n;
    logic [31:0]     op_a;
    logic [31:0]     op_b;
    logic [31:0]     conv_in;
    logic [FX_W-1:0] core_fx;
    logic [FX_W-1:0] fx_sat;
    logic [FX_W-1:0] fx_a;
    logic [FX_W-1:0] fx_b;
    logic [ACC_W-1:0] ext_a;
    logic [ACC_W-1:0] ext_b;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;

    fx_conv_core u_core (
        .fp (conv_in),
        .fx (core_fx)
    );

    // Converter operand mux and clamp; exp >= 128 is just the top exponent bit
    always_comb begin
        conv_in = (state == CONV_B) ? op_b : op_a;
        fx_sat  = conv_in[30] ? fx_clamp(conv_in[31]) : core_fx;
        ext_a   = ACC_W'($signed(fx_a));
        ext_b   = ACC_W'($signed(fx_b));
        acc_sum = acc + ext_a;
    end

    // Next-state logic: second conversion only for SUM2
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONV_A;
            CONV_A:  state_nxt = (op_n == SUM2) ? CONV_B : COMBINE;
            CONV_B:  state_nxt = COMBINE;
            COMBINE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, frozen while clk_en is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (clk_en) begin
            state <= state_nxt;
        end
    end

    // Operand capture at start and per-operand conversion results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a <= '0;
            op_b <= '0;
            op_n <= CONV;
            fx_a <= '0;
            fx_b <= '0;
        end else if (clk_en) begin
            if (state == IDLE && start) begin
                op_a <= dataa;
                op_b <= datab;
                op_n <= op_t'(n);
            end
            if (state == CONV_A) fx_a <= fx_sat;
            if (state == CONV_B) fx_b <= fx_sat;
        end
    end

    // Combine stage: result, accumulator update and the one-cycle done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= '0;
            acc    <= '0;
            done   <= 1'b0;
        end else if (clk_en) begin
            done <= (state == COMBINE);
            if (state == COMBINE) begin
                case (op_n)
                    CONV:    result <= ext_a;
                    SUM2:    result <= ext_a + ext_b;
                    ACC: begin
                        result <= acc_sum;
                        acc    <= acc_sum;
                    end
                    READCLR: begin
                        result <= acc;
                        acc    <= '0;
                    end
                    default: result <= ext_a;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fx_conv_ci_ctrl.sv
// tb/tb_fx_conv_ci_ctrl.sv - scoreboard bench for fx_conv_ci_ctrl
module tb_fx_conv_ci_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  n = 2'd0;
    logic [31:0] dataa = 32'h0;
    logic [31:0] datab = 32'h0;
    logic [31:0] result;
    logic        done;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    fx_conv_ci_ctrl #(.ACC_W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .n      (n),
        .dataa  (dataa),
        .datab  (datab),
        .result (result),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every enabled done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && done && clk_en) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done cyc=%0d result=%08h required=no done", cyc, result);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (result !== e.res) begin
                    errors++;
                    $display("FAIL %s result actual=%08h required=%08h", e.name, result, e.res);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL %s latency done_cycle actual=%0d required=%0d", e.name, cyc, e.cyc);
                end
            end
        end
    end

    // Start one instruction; lat is the done cycle counted from the start cycle
    task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int lat,
                         input bit expect_done);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1;
        n     = op;
        dataa = a;
        datab = b;
        if (expect_done) begin
            e.res  = exp_res;
            e.cyc  = cyc + lat;
            e.name = name;
            q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
        dataa = 32'hDEADBEEF;
        datab = 32'hC0FFEE00;
        n     = 2'd3;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout pending=%0d required=0", name, q.size());
            q.delete();
        end
    endtask

    task automatic run(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res);
        issue(name, op, a, b, exp_res, (op == 2'd1) ? 4 : 3, 1'b1);
        drain(name);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (result !== 32'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state result=%08h done=%0b required=00000000/0", result, done);
        end
        reset = 1'b0;

        run("conv_1p0",   2'd0, 32'h3F800000, 32'h0, 32'h00400000);
        run("conv_m0p5",  2'd0, 32'hBF000000, 32'h0, 32'hFFE00000);
        run("conv_zero",  2'd0, 32'h00000000, 32'h0, 32'h00000000);
        run("conv_1p5",   2'd0, 32'h3FC00000, 32'h0, 32'h00600000);
        run("conv_tiny",  2'd0, 32'h33800000, 32'h0, 32'h00000000);
        run("sat_3p0",    2'd0, 32'h40400000, 32'h0, 32'h007FFFFF);
        run("sat_m3p0",   2'd0, 32'hC0400000, 32'h0, 32'hFF800000);
        run("sat_inf",    2'd0, 32'h7F800000, 32'h0, 32'h007FFFFF);
        run("sat_2p0",    2'd0, 32'h40000000, 32'h0, 32'h007FFFFF);
        run("sum2",       2'd1, 32'h3F800000, 32'hBF000000, 32'h00200000);
        run("sum2_sat",   2'd1, 32'hC0400000, 32'h3F800000, 32'hFFC00000);

        run("acc_1",      2'd2, 32'h3F800000, 32'h0, 32'h00400000);
        run("acc_2",      2'd2, 32'h3F800000, 32'h0, 32'h00800000);
        run("acc_3",      2'd2, 32'h3F800000, 32'h0, 32'h00C00000);
        run("readclr_1",  2'd3, 32'h3F800000, 32'h0, 32'h00C00000);
        run("readclr_2",  2'd3, 32'h3F800000, 32'h0, 32'h00000000);

        // Stall two cycles while in CONV_A
        issue("stall_conv", 2'd0, 32'h3F800000, 32'h0, 32'h00400000, 5, 1'b1);
        clk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clk_en = 1'b1;
        drain("stall_conv");

        // Second start during CONV_A must be ignored
        issue("ignore_start", 2'd0, 32'h3F800000, 32'h0, 32'h00400000, 3, 1'b1);
        start = 1'b1;
        n     = 2'd1;
        dataa = 32'h40400000;
        @(posedge clk); #1;
        start = 1'b0;
        drain("ignore_start");
        repeat (6) @(posedge clk);

        // Reset in CONV_A of a third ACC aborts it
        run("racc_1", 2'd2, 32'h3F800000, 32'h0, 32'h00400000);
        run("racc_2", 2'd2, 32'h3F800000, 32'h0, 32'h00800000);
        issue("racc_abort", 2'd2, 32'h3F800000, 32'h0, 32'h0, 3, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if (result !== 32'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset result=%08h done=%0b required=00000000/0", result, done);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        run("readclr_after_reset", 2'd3, 32'h3F800000, 32'h0, 32'h00000000);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
